// File: rtl/secure_drain_reader_if.sv
// ---------------------------------------------------------------------------
// secure_drain_reader_if
//   Bundles every non-clock signal of the secure drain reader:
//     wr_ptr / rd_ptr        : AW+1 bit ring pointers, MSB is the wrap bit
//     mem_rd_en / mem_scrub_en / mem_addr / mem_rd_data : buffer access port
//     m_valid / m_data / m_ready : downstream stream
//     flush / busy           : purge request and activity status
//   master : the reader (drives rd_ptr, memory strobes, stream, busy)
//   slave  : the environment (buffer, writer, downstream sink)
//
// Handshake: a beat transfers on a rising clk edge where m_valid and m_ready
// are both high and flush is low. Once m_valid rises, m_valid and m_data hold
// steady until that transfer (or a flush) happens; m_ready may be driven
// freely and never depends on m_valid. m_data is all-zero while m_valid is low.
// ---------------------------------------------------------------------------
interface secure_drain_reader_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          mem_rd_en;
    logic          mem_scrub_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          flush;
    logic          busy;

    modport master (
        input  wr_ptr, mem_rd_data, m_ready, flush,
        output rd_ptr, mem_rd_en, mem_scrub_en, mem_addr, m_valid, m_data, busy
    );

    modport slave (
        output wr_ptr, mem_rd_data, m_ready, flush,
        input  rd_ptr, mem_rd_en, mem_scrub_en, mem_addr, m_valid, m_data, busy
    );
endinterface

// File: rtl/secure_drain_reader.sv
// ---------------------------------------------------------------------------
// secure_drain_reader
//   Read end of a 2**AW entry sensitive-data ring buffer. Entries are popped
//   in FIFO order, presented on a valid/ready stream, and each consumed slot
//   is overwritten with zero. The holding register is wiped after every
//   handoff, and a flush scrubs every pending entry without emitting it.
//
// Ports
//   clk        : single clock, everything on posedge
//   rst        : synchronous active-high reset
//   bus        : secure_drain_reader_if.master (pointers, memory port, stream)
//   dbg_state  : current FSM state encoding (IDLE=0, FETCH=1, CAPT=2,
//                PRESENT=3, SCRUB=4, PURGE=5)
//
// All outputs are decoded from registered state, so the buffer read strobe,
// scrub strobe and stream valid are glitch-free functions of the FSM.
// ---------------------------------------------------------------------------
module secure_drain_reader #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    secure_drain_reader_if.master        bus,
    output logic [2:0]                   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPT    = 3'd2,
        S_PRESENT = 3'd3,
        S_SCRUB   = 3'd4,
        S_PURGE   = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   tgt_q, tgt_d;          // purge stop point, frozen on PURGE entry
    logic [DW-1:0] hold_q, hold_d;        // the only copy of sensitive data held here
    logic          flush_pend_q, flush_pend_d;

    // Combinational outputs
    logic          mem_rd_en_c;
    logic          mem_scrub_en_c;
    logic [AW-1:0] mem_addr_c;
    logic          m_valid_c;
    logic [DW-1:0] m_data_c;

    logic          empty;
    logic          purge_left;

    // Empty compares all AW+1 bits; equal slots with different wrap bits means full.
    assign empty      = (rd_ptr_q == bus.wr_ptr);
    assign purge_left = (rd_ptr_q != tgt_q);

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        tgt_d          = tgt_q;
        hold_d         = hold_q;
        flush_pend_d   = flush_pend_q;
        mem_rd_en_c    = 1'b0;
        mem_scrub_en_c = 1'b0;
        mem_addr_c     = '0;
        m_valid_c      = 1'b0;
        m_data_c       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.flush || flush_pend_q) begin
                    state_d = S_PURGE;
                end else if (!empty) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_rd_en_c = 1'b1;
                mem_addr_c  = rd_ptr_q[AW-1:0];
                // A flush here cannot abort the read already issued; remember it
                // and divert after capture.
                if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
                state_d = S_CAPT;
            end

            S_CAPT: begin
                hold_d = bus.mem_rd_data;
                if (bus.flush || flush_pend_q) begin
                    state_d = S_PURGE;
                end else begin
                    state_d = S_PRESENT;
                end
            end

            S_PRESENT: begin
                m_valid_c = 1'b1;
                m_data_c  = hold_q;
                // Flush wins over m_ready: the entry is purged, not delivered.
                if (bus.flush) begin
                    state_d = S_PURGE;
                end else if (bus.m_ready) begin
                    state_d = S_SCRUB;
                end
            end

            S_SCRUB: begin
                mem_scrub_en_c = 1'b1;
                mem_addr_c     = rd_ptr_q[AW-1:0];
                hold_d         = '0;
                rd_ptr_d       = rd_ptr_q + 1'b1;
                if (bus.flush || flush_pend_q) begin
                    state_d = S_PURGE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_PURGE: begin
                // flush is ignored here; the target was fixed on entry, so
                // entries written during the purge survive it.
                if (purge_left) begin
                    mem_scrub_en_c = 1'b1;
                    mem_addr_c     = rd_ptr_q[AW-1:0];
                    rd_ptr_d       = rd_ptr_q + 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The held word is wiped the moment PRESENT is left, whether by
        // handoff or by flush, so it never lingers into SCRUB or PURGE.
        if ((state_q == S_PRESENT) && (state_d != S_PRESENT)) begin
            hold_d = '0;
        end

        // Entering PURGE: freeze the stop point and drop any captured data.
        // This overrides the CAPT load when CAPT diverts to PURGE.
        if ((state_d == S_PURGE) && (state_q != S_PURGE)) begin
            tgt_d        = bus.wr_ptr;
            hold_d       = '0;
            flush_pend_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            tgt_q        <= '0;
            hold_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            tgt_q        <= tgt_d;
            hold_q       <= hold_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.mem_rd_en    = mem_rd_en_c;
    assign bus.mem_scrub_en = mem_scrub_en_c;
    assign bus.mem_addr     = mem_addr_c;
    assign bus.m_valid      = m_valid_c;
    assign bus.m_data       = m_data_c;
    assign bus.busy         = (state_q != S_IDLE);
    assign dbg_state        = state_q;

    // -----------------------------------------------------------------------
    // Invariants
    // -----------------------------------------------------------------------
    a_one_strobe : assert property (@(posedge clk) disable iff (rst)
        !(mem_rd_en_c && mem_scrub_en_c));

    a_data_zero_when_idle : assert property (@(posedge clk) disable iff (rst)
        !m_valid_c |-> (m_data_c == '0));

    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (m_valid_c && !bus.m_ready && !bus.flush) |=> (m_valid_c && $stable(m_data_c)));

endmodule

// File: tb/tb_secure_drain_reader.sv
module tb_secure_drain_reader;
  localparam int DW = 32;
  localparam int AW = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_CAPT    = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_SCRUB   = 3'd4;
  localparam logic [2:0] ST_PURGE   = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  secure_drain_reader_if #(.DW(DW), .AW(AW)) bus ();

  secure_drain_reader #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- buffer model ----------------
  logic [DW-1:0] mem [16];
  logic          tb_wr_en;
  logic [AW-1:0] tb_wr_addr;
  logic [DW-1:0] tb_wr_data;

  always @(posedge clk) begin
    if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
    if (bus.mem_scrub_en) mem[bus.mem_addr] <= '0;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
    else bus.mem_rd_data <= $urandom;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q[$];
  int n_xfer = 0, n_scrub = 0, n_valid_cyc = 0, n_both = 0, n_dirty = 0;
  int scrub_run = 0, last_run = 0;
  int scrub_cnt[16];
  logic saw_wrap = 1'b0;
  logic [AW:0] prev_rd = '0;

  initial for (int i = 0; i < 16; i++) scrub_cnt[i] = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid) n_valid_cyc++;
      if (bus.mem_rd_en && bus.mem_scrub_en) n_both++;
      if (!bus.m_valid && (bus.m_data != '0)) n_dirty++;
      if (bus.mem_scrub_en) begin
        n_scrub++;
        scrub_cnt[bus.mem_addr]++;
        scrub_run++;
      end else if (scrub_run != 0) begin
        last_run  = scrub_run;
        scrub_run = 0;
      end
      if (prev_rd == 5'h0F && bus.rd_ptr == 5'h10) saw_wrap = 1'b1;
      prev_rd = bus.rd_ptr;
      if (bus.m_valid && bus.m_ready && !bus.flush) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL stream_unexpected: got data %0h, expected no transfer", bus.m_data);
        end else begin
          check("stream_data", bus.m_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [AW-1:0] slot, input logic [DW-1:0] val);
    tb_wr_en   = 1'b1;
    tb_wr_addr = slot;
    tb_wr_data = val;
    tick();
    tb_wr_en   = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    for (int i = 0; i < budget && dbg_state != st; i++) tick();
    check(name, dbg_state, st);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW:0]   wr_ptr;
    logic          m_ready;
    logic          flush;
    logic [2:0]    st;
    logic          mv;
    logic [DW-1:0] md;
    logic          rd_en;
    logic          scrub;
    logic [AW-1:0] addr;
    logic [AW:0]   rp;
    logic          busy;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int sc0, xf0, va0, bad, n_wr, nz, exp_cnt;
    int snap[16];
    logic [DW-1:0] val;
    logic [AW:0] diff;
    logic done;

    // single transfer of 0xCAFEF00D, then a flush caught in CAPT
    vecs[0]  = '{5'd1, 1'b1, 1'b0, ST_IDLE,    1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 5'd0, 1'b0};
    vecs[1]  = '{5'd1, 1'b1, 1'b0, ST_FETCH,   1'b0, 32'h0,        1'b1, 1'b0, 4'd0, 5'd0, 1'b1};
    vecs[2]  = '{5'd1, 1'b1, 1'b0, ST_CAPT,    1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 5'd0, 1'b1};
    vecs[3]  = '{5'd1, 1'b1, 1'b0, ST_PRESENT, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 4'd0, 5'd0, 1'b1};
    vecs[4]  = '{5'd1, 1'b1, 1'b0, ST_SCRUB,   1'b0, 32'h0,        1'b0, 1'b1, 4'd0, 5'd0, 1'b1};
    vecs[5]  = '{5'd1, 1'b1, 1'b0, ST_IDLE,    1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 5'd1, 1'b0};
    vecs[6]  = '{5'd2, 1'b1, 1'b0, ST_IDLE,    1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 5'd1, 1'b0};
    vecs[7]  = '{5'd2, 1'b1, 1'b0, ST_FETCH,   1'b0, 32'h0,        1'b1, 1'b0, 4'd1, 5'd1, 1'b1};
    vecs[8]  = '{5'd2, 1'b1, 1'b1, ST_CAPT,    1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 5'd1, 1'b1};
    vecs[9]  = '{5'd2, 1'b1, 1'b0, ST_PURGE,   1'b0, 32'h0,        1'b0, 1'b1, 4'd1, 5'd1, 1'b1};
    vecs[10] = '{5'd2, 1'b1, 1'b0, ST_PURGE,   1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 5'd2, 1'b1};
    vecs[11] = '{5'd2, 1'b1, 1'b0, ST_IDLE,    1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 5'd2, 1'b0};

    rst = 1'b1;
    bus.wr_ptr = '0;
    bus.m_ready = 1'b0;
    bus.flush = 1'b0;
    tb_wr_en = 1'b0;
    tb_wr_addr = '0;
    tb_wr_data = '0;
    repeat (3) tick();

    // reset state
    check("rst_state",   dbg_state, ST_IDLE);
    check("rst_rd_ptr",  bus.rd_ptr, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data",  bus.m_data, 0);
    check("rst_rd_en",   bus.mem_rd_en, 0);
    check("rst_scrub",   bus.mem_scrub_en, 0);
    check("rst_addr",    bus.mem_addr, 0);
    check("rst_busy",    bus.busy, 0);
    rst = 1'b0;

    // table: single transfer then flush in CAPT
    mem_write(4'd0, 32'hCAFEF00D);
    mem_write(4'd1, 32'h12345678);
    exp_q.push_back(32'hCAFEF00D);
    for (int r = 0; r < 12; r++) begin
      bus.wr_ptr  = vecs[r].wr_ptr;
      bus.m_ready = vecs[r].m_ready;
      bus.flush   = vecs[r].flush;
      @(negedge clk);
      check($sformatf("v%0d_state", r),  dbg_state,        vecs[r].st);
      check($sformatf("v%0d_valid", r),  bus.m_valid,      vecs[r].mv);
      check($sformatf("v%0d_data", r),   bus.m_data,       vecs[r].md);
      check($sformatf("v%0d_rd_en", r),  bus.mem_rd_en,    vecs[r].rd_en);
      check($sformatf("v%0d_scrub", r),  bus.mem_scrub_en, vecs[r].scrub);
      check($sformatf("v%0d_addr", r),   bus.mem_addr,     vecs[r].addr);
      check($sformatf("v%0d_rd_ptr", r), bus.rd_ptr,       vecs[r].rp);
      check($sformatf("v%0d_busy", r),   bus.busy,         vecs[r].busy);
      tick();
    end
    bus.flush = 1'b0;
    check("t1_slot0_scrubbed", mem[0], 0);
    check("t6_slot1_scrubbed", mem[1], 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // backpressure: 10 cycles of m_ready=0 in PRESENT
    val = 32'hA5A5_0F0F;
    mem_write(4'd2, val);
    bus.m_ready = 1'b0;
    bus.wr_ptr = 5'd3;
    exp_q.push_back(val);
    sc0 = n_scrub;
    xf0 = n_xfer;
    wait_state(ST_PRESENT, 10, "bp_reach_present");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(bus.m_valid && bus.m_data == val && !bus.mem_scrub_en && bus.rd_ptr == 5'd2)) bad++;
      tick();
    end
    check("bp_stable_cycles_bad", bad, 0);
    check("bp_no_scrub", n_scrub - sc0, 0);
    bus.m_ready = 1'b1;
    wait_state(ST_IDLE, 10, "bp_back_idle");
    check("bp_rd_ptr", bus.rd_ptr, 5'd3);
    check("bp_one_scrub", n_scrub - sc0, 1);
    check("bp_one_xfer", n_xfer - xf0, 1);

    // 20 streamed entries from a fresh reset, wrapping the ring
    rst = 1'b1;
    bus.wr_ptr = '0;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) snap[i] = scrub_cnt[i];
    n_wr = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      tb_wr_en = 1'b0;
      diff = bus.wr_ptr - bus.rd_ptr;
      if (n_wr < 20 && diff < 5'd16) begin
        val = $urandom;
        tb_wr_en   = 1'b1;
        tb_wr_addr = bus.wr_ptr[AW-1:0];
        tb_wr_data = val;
        exp_q.push_back(val);
        bus.wr_ptr = bus.wr_ptr + 1'b1;
        n_wr++;
      end
      tick();
      if (n_wr == 20 && exp_q.size() == 0 && dbg_state == ST_IDLE) done = 1'b1;
    end
    tb_wr_en = 1'b0;
    check("stream_done", done, 1);
    check("stream_rd_ptr", bus.rd_ptr, 5'h14);
    check("stream_wrapped", saw_wrap, 1);
    for (int i = 0; i < 16; i++) begin
      exp_cnt = (i < 4) ? 2 : 1;
      check($sformatf("stream_scrubs_slot%0d", i), scrub_cnt[i] - snap[i], exp_cnt);
    end
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== '0) nz++;
    check("stream_mem_zeroed", nz, 0);

    // 6 pending entries, flush while PRESENT with m_ready=1
    for (int i = 4; i < 10; i++) mem_write(i[AW-1:0], $urandom | 32'h1);
    sc0 = n_scrub;
    xf0 = n_xfer;
    bus.m_ready = 1'b1;
    bus.wr_ptr = 5'd26;
    wait_state(ST_PRESENT, 10, "fp_reach_present");
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fp_in_purge", dbg_state, ST_PURGE);
    va0 = n_valid_cyc;
    wait_state(ST_IDLE, 20, "fp_back_idle");
    check("fp_rd_ptr", bus.rd_ptr, 5'd26);
    check("fp_scrubs", n_scrub - sc0, 6);
    check("fp_consecutive", last_run, 6);
    check("fp_no_xfer", n_xfer - xf0, 0);
    check("fp_no_revalid", n_valid_cyc - va0, 0);
    nz = 0;
    for (int i = 4; i < 10; i++) if (mem[i] !== '0) nz++;
    check("fp_mem_zeroed", nz, 0);

    // flush in FETCH: pending flag diverts CAPT to PURGE
    mem_write(4'd10, 32'h5EC2E7);
    xf0 = n_xfer;
    bus.wr_ptr = 5'd27;
    wait_state(ST_FETCH, 5, "ff_reach_fetch");
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("ff_capt", dbg_state, ST_CAPT);
    tick();
    check("ff_purge", dbg_state, ST_PURGE);
    check("ff_m_data", bus.m_data, 0);
    wait_state(ST_IDLE, 10, "ff_back_idle");
    check("ff_rd_ptr", bus.rd_ptr, 5'd27);
    check("ff_no_xfer", n_xfer - xf0, 0);
    check("ff_slot_zeroed", mem[10], 0);

    // reset during SCRUB
    mem_write(4'd11, 32'h0BAD_F00D);
    exp_q.push_back(32'h0BAD_F00D);
    bus.wr_ptr = 5'd28;
    wait_state(ST_SCRUB, 10, "rs_reach_scrub");
    rst = 1'b1;
    bus.wr_ptr = '0;
    tick();
    check("rs_state",   dbg_state, ST_IDLE);
    check("rs_rd_ptr",  bus.rd_ptr, 0);
    check("rs_m_valid", bus.m_valid, 0);
    check("rs_m_data",  bus.m_data, 0);
    check("rs_rd_en",   bus.mem_rd_en, 0);
    check("rs_scrub",   bus.mem_scrub_en, 0);
    check("rs_busy",    bus.busy, 0);
    rst = 1'b0;
    tick();
    check("rs_stays_idle", dbg_state, ST_IDLE);

    // run-wide invariants
    check("inv_strobes_exclusive", n_both, 0);
    check("inv_m_data_zero", n_dirty, 0);
    check("inv_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
